// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between two requesters. Port 0 is the
// core load/store path and port 1 is the debug/loader path. Requests use a
// req/ack handshake and are served strictly one at a time, round-robin:
//
//   IDLE   : pick a winner, latch its command (we/addr/wdata)
//   ACCESS : drive the memory from the latched command for one cycle;
//            read data is captured at the closing edge
//   DONE   : registered one-cycle ack to the winner, then back to IDLE
//
// One access therefore takes three cycles, and a requester that keeps req
// high after its ack competes again in the next IDLE cycle.
//
// Optional build macro: DMEM_ARB_LOCK_EN
//   Adds input lock0, latched with each port 0 command. A port 0 access
//   that completes with lock0=1 makes port 0 the only grantable port until
//   a port 0 access completes with lock0=0 (atomic read-modify-write).
//   Without the macro there is no lock0 port and arbitration is pure
//   round-robin.
//
// Ports
//   clk, nReset            clock, synchronous active-low reset
//   req0/we0/addr0/wdata0  port 0 command (held stable while req0 is high)
//   lock0                  port 0 lock request (DMEM_ARB_LOCK_EN only)
//   ack0, rdata0           port 0 completion pulse and captured read data
//   req1/.../rdata1        same for port 1
//   mem_we/mem_addr/mem_wdata  memory command, mem_we only high in ACCESS
//   mem_rdata              combinational memory read data
//   busy                   high while an access is in flight (ACCESS, DONE)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
`ifdef DMEM_ARB_LOCK_EN
  input  logic                  lock0,
`endif
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;

  // Port that was granted most recently; reset to 1 so port 0 wins the
  // first tie.
  logic                    last_grant_reg;
  // Port whose command is currently in flight.
  logic                    winner_reg;

  // Command registers. mem_addr/mem_wdata are driven straight from these, so
  // they naturally hold their last value outside ACCESS.
  logic                    cmd_we_reg;
  logic [ADDR_WIDTH-1:0]   cmd_addr_reg;
  logic [DATA_WIDTH-1:0]   cmd_wdata_reg;

  logic                    grant_valid;
  logic                    grant_port;
  logic                    port1_blocked;

  // Per-port views of the request inputs so the command mux is indexed.
  logic [1:0]              req_vec;
  logic [1:0]              we_vec;
  logic [ADDR_WIDTH-1:0]   addr_vec  [2];
  logic [DATA_WIDTH-1:0]   wdata_vec [2];

  assign req_vec      = {req1, req0};
  assign we_vec       = {we1, we0};
  assign addr_vec[0]  = addr0;
  assign addr_vec[1]  = addr1;
  assign wdata_vec[0] = wdata0;
  assign wdata_vec[1] = wdata1;

  // ---------------------------------------------------------------------------
  // Optional lock: port 0 may hold the memory across several accesses.
  // ---------------------------------------------------------------------------
`ifdef DMEM_ARB_LOCK_EN
  logic lock_own_reg;
  logic cmd_lock_reg;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      lock_own_reg <= 1'b0;
      cmd_lock_reg <= 1'b0;
    end else begin
      if (grant_valid && (grant_port == 1'b0)) begin
        cmd_lock_reg <= lock0;
      end
      // Ownership only changes when a port 0 access actually completes.
      if ((state_reg == ACCESS) && (winner_reg == 1'b0)) begin
        lock_own_reg <= cmd_lock_reg;
      end
    end
  end

  assign port1_blocked = lock_own_reg;
`else
  assign port1_blocked = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    grant_valid = 1'b0;
    grant_port  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req_vec[0] && req_vec[1] && !port1_blocked) begin
          // Contention: the port that did not win last time goes now.
          grant_valid = 1'b1;
          grant_port  = ~last_grant_reg;
        end else if (req_vec[0]) begin
          grant_valid = 1'b1;
          grant_port  = 1'b0;
        end else if (req_vec[1] && !port1_blocked) begin
          grant_valid = 1'b1;
          grant_port  = 1'b1;
        end

        if (grant_valid) begin
          state_next = ACCESS;
        end
      end

      ACCESS: begin
        state_next = DONE;
      end

      // Requests are not looked at here; a requester that keeps req high
      // is picked up again in the following IDLE cycle.
      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and command registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      winner_reg     <= 1'b0;
      cmd_we_reg     <= 1'b0;
      cmd_addr_reg   <= '0;
      cmd_wdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (grant_valid) begin
        last_grant_reg <= grant_port;
        winner_reg     <= grant_port;
        cmd_we_reg     <= we_vec[grant_port];
        cmd_addr_reg   <= addr_vec[grant_port];
        cmd_wdata_reg  <= wdata_vec[grant_port];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-port completion: registered ack and read-data capture
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      localparam logic PORT_ID = 1'(gi);

      logic                  ack_reg;
      logic [DATA_WIDTH-1:0] rdata_reg;

      always_ff @(posedge clk) begin
        if (!nReset) begin
          ack_reg   <= 1'b0;
          rdata_reg <= '0;
        end else begin
          // The ack lands in DONE: it is set on the edge that closes ACCESS.
          ack_reg <= (state_reg == ACCESS) && (winner_reg == PORT_ID);
          if ((state_reg == ACCESS) && (winner_reg == PORT_ID) && !cmd_we_reg) begin
            rdata_reg <= mem_rdata;
          end
        end
      end
    end
  endgenerate

  assign ack0   = g_port[0].ack_reg;
  assign rdata0 = g_port[0].rdata_reg;
  assign ack1   = g_port[1].ack_reg;
  assign rdata1 = g_port[1].rdata_reg;

  // ---------------------------------------------------------------------------
  // Memory interface
  // ---------------------------------------------------------------------------
  assign mem_we    = (state_reg == ACCESS) && cmd_we_reg;
  assign mem_addr  = cmd_addr_reg;
  assign mem_wdata = cmd_wdata_reg;
  assign busy      = (state_reg != IDLE);

endmodule
